mx_block_align: RTL and testbench

Block quantiser converting a stream of individually scaled integers, such as the normalised (value, scale) pairs produced by the adder/normaliser path, back into MX block format. It collects `block_k` elements, determines the shared (maximum) scale and right-aligns every element to it. Each element is then rounded and narrowed to `out_w` bits and emitted as one MX block. It sits at the output of the accumulation datapath, ahead of MX storage and packing.

---
 rtl/mx_block_align.sv | 150 +++++++++++++++
 tb/tb_mx_block_align.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mx_block_align.sv
// Block quantiser: collects block_k (value, scale) pairs, aligns each to the shared maximum scale
// and emits them as one MX block. Define MX_ALIGN_RNE_EN for round-to-nearest-even with saturation.
module mx_block_align #(
   parameter int int_w   = 24,
   parameter int scale_w = 8,
   parameter int out_w   = 8,
   parameter int block_k = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [int_w-1:0]   i_op,
   input  logic [scale_w-1:0] i_scale,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [out_w-1:0]   o_data,
   output logic [scale_w-1:0] o_scale,
   output logic               o_last
);
   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // valid never depends on ready, and the output holds data/scale/last stable while valid && !ready.
   localparam int CNT_W = $clog2(block_k);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(block_k - 1);

   typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   wr_cnt_q;
   logic [CNT_W-1:0]   rd_cnt_q;
   logic [scale_w-1:0] max_scale_q;
   logic [scale_w-1:0] max_scale_d;
   logic               o_valid_q;
   logic [out_w-1:0]   o_data_q;
   logic [scale_w-1:0] o_scale_q;
   logic               o_last_q;

   logic [int_w-1:0]   op_buf_q [block_k];
   logic [scale_w-1:0] sc_buf_q [block_k];

   logic               accept;
   logic               last_in;
   logic [CNT_W-1:0]   ld_idx;
   logic [scale_w-1:0] ld_max;
   logic [int_w-1:0]   al_op;
   logic [int_w-1:0]   sh;
   logic [scale_w-1:0] diff;
   logic               big;
   logic [out_w-1:0]   cand;
   logic [out_w-1:0]   aligned;

   assign o_ready = (state_q == COLLECT);
   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_scale = o_scale_q;
   assign o_last  = o_last_q;

   assign accept  = o_ready & i_valid;
   assign last_in = accept & (wr_cnt_q == LAST_IDX);

   always_comb begin
      max_scale_d = max_scale_q;
      if (wr_cnt_q == '0 || i_scale > max_scale_q) max_scale_d = i_scale;
   end

   // Element 0 is loaded on the same edge that accepts the last input, so it needs the new maximum.
   assign ld_idx = (state_q == COLLECT) ? '0 : rd_cnt_q + CNT_W'(1);
   assign ld_max = (state_q == COLLECT) ? max_scale_d : max_scale_q;

   always_comb begin
      al_op = op_buf_q[ld_idx];
      diff  = ld_max - sc_buf_q[ld_idx];
      big   = 32'(diff) >= 32'(int_w);
      sh    = big ? {int_w{al_op[int_w-1]}} : int_w'($signed(al_op) >>> diff);
      cand  = out_w'(sh >> (int_w - out_w));
   end

`ifdef MX_ALIGN_RNE_EN
   localparam logic [int_w-1:0] GUARD_BIT = int_w'(1) << (int_w - out_w - 1);
   localparam logic [out_w-1:0] MAX_POS   = {1'b0, {(out_w-1){1'b1}}};
   logic [int_w-1:0] lost_mask;
   logic             guard;
   logic             sticky;
   logic             round_up;

   always_comb begin
      lost_mask = big ? '1 : ~({int_w{1'b1}} << diff);
      guard     = |(sh & GUARD_BIT);
      sticky    = (|(sh & (GUARD_BIT - int_w'(1)))) | (|(al_op & lost_mask));
      round_up  = guard & (sticky | cand[0]);
      if (round_up && cand == MAX_POS) aligned = MAX_POS;
      else                             aligned = cand + out_w'(round_up);
   end
`else
   assign aligned = cand;
`endif

   always_ff @(posedge i_clk) begin
      if (accept) begin
         op_buf_q[wr_cnt_q] <= i_op;
         sc_buf_q[wr_cnt_q] <= i_scale;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= COLLECT;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         max_scale_q <= '0;
         o_valid_q   <= 1'b0;
         o_data_q    <= '0;
         o_scale_q   <= '0;
         o_last_q    <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (accept) begin
                  max_scale_q <= max_scale_d;
                  if (last_in) begin
                     state_q   <= EMIT;
                     wr_cnt_q  <= '0;
                     rd_cnt_q  <= '0;
                     o_valid_q <= 1'b1;
                     o_data_q  <= aligned;
                     o_scale_q <= max_scale_d;
                     o_last_q  <= 1'b0;
                  end else begin
                     wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                  end
               end
            end
            EMIT: begin
               if (o_valid_q && i_ready) begin
                  if (o_last_q) begin
                     state_q   <= COLLECT;
                     o_valid_q <= 1'b0;
                     o_last_q  <= 1'b0;
                  end else begin
                     rd_cnt_q <= ld_idx;
                     o_data_q <= aligned;
                     o_last_q <= (ld_idx == LAST_IDX);
                  end
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_mx_block_align.sv
// Directed bench for mx_block_align with block_k = 4; expectations follow the build's
// MX_ALIGN_RNE_EN setting (rounding on when defined, truncation otherwise).
module tb_mx_block_align;
   localparam int INT_W   = 24;
   localparam int SCALE_W = 8;
   localparam int OUT_W   = 8;
   localparam int BLOCK_K = 4;

   logic               i_clk;
   logic               i_rst_n;
   logic               i_valid;
   logic               o_ready;
   logic [INT_W-1:0]   i_op;
   logic [SCALE_W-1:0] i_scale;
   logic               o_valid;
   logic               i_ready;
   logic [OUT_W-1:0]   o_data;
   logic [SCALE_W-1:0] o_scale;
   logic               o_last;

   int n_assert = 0;
   int n_fail   = 0;

   logic [OUT_W-1:0]   exp_q[$];
   logic [INT_W-1:0]   blk_op  [BLOCK_K];
   logic [SCALE_W-1:0] blk_sc  [BLOCK_K];
   logic [OUT_W-1:0]   blk_exp [BLOCK_K];

   mx_block_align #(
      .int_w(INT_W), .scale_w(SCALE_W), .out_w(OUT_W), .block_k(BLOCK_K)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_scale(i_scale), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_scale(o_scale), .o_last(o_last)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [INT_W-1:0] op, input logic [SCALE_W-1:0] sc);
      @(negedge i_clk);
      i_valid = 1'b1;
      i_op    = op;
      i_scale = sc;
      @(posedge i_clk);
   endtask

   task automatic pop_elem(input string tag, input int idx, input logic [SCALE_W-1:0] sc_exp,
                           input bit stall);
      logic [OUT_W-1:0] exp_d;
      int waited;
      waited = 0;
      while (o_valid !== 1'b1 && waited < 20) begin
         @(negedge i_clk);
         waited++;
      end
      check($sformatf("%s valid e%0d", tag, idx), 32'(o_valid), 1);
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (stall) begin
         repeat ($urandom_range(0, 2)) begin
            i_ready = 1'b0;
            @(negedge i_clk);
            check($sformatf("%s stall data e%0d", tag, idx), 32'(o_data), 32'(exp_d));
            check($sformatf("%s stall valid e%0d", tag, idx), 32'(o_valid), 1);
         end
      end
      check($sformatf("%s data e%0d", tag, idx), 32'(o_data), 32'(exp_d));
      check($sformatf("%s scale e%0d", tag, idx), 32'(o_scale), 32'(sc_exp));
      check($sformatf("%s last e%0d", tag, idx), 32'(o_last), (idx == BLOCK_K - 1) ? 1 : 0);
      check($sformatf("%s ready e%0d", tag, idx), 32'(o_ready), 0);
      i_ready = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic run_block(input string tag, input logic [SCALE_W-1:0] sc_exp, input bit rough);
      for (int i = 0; i < BLOCK_K; i++) begin
         if (rough) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge i_clk);
               i_valid = 1'b0;
               i_op    = INT_W'($urandom);
            end
         end
         push(blk_op[i], blk_sc[i]);
         exp_q.push_back(blk_exp[i]);
      end
      @(negedge i_clk);
      // In rough mode junk is offered throughout the output phase; it must be ignored.
      i_valid = rough;
      i_op    = 24'h7FFFFF;
      i_scale = 8'hFF;
      check({tag, " latency valid"}, 32'(o_valid), 1);
      check({tag, " ready in emit"}, 32'(o_ready), 0);
      for (int i = 0; i < BLOCK_K; i++) pop_elem(tag, i, sc_exp, rough);
      check({tag, " ready after last"}, 32'(o_ready), 1);
      check({tag, " valid after last"}, 32'(o_valid), 0);
      i_valid = 1'b0;
   endtask

   task automatic pulse_reset(input string tag);
      #2 i_rst_n = 1'b0;
      #1;
      check({tag, " reset valid"}, 32'(o_valid), 0);
      check({tag, " reset last"}, 32'(o_last), 0);
      check({tag, " reset data"}, 32'(o_data), 0);
      check({tag, " reset scale"}, 32'(o_scale), 0);
      check({tag, " reset ready"}, 32'(o_ready), 1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_op    = '0;
      i_scale = '0;

      // Reset state
      #12;
      check("por valid", 32'(o_valid), 0);
      check("por data", 32'(o_data), 0);
      check("por scale", 32'(o_scale), 0);
      check("por last", 32'(o_last), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("por ready", 32'(o_ready), 1);

      // Basic alignment to max scale 5
      blk_op  = '{24'h400000, 24'h400000, 24'hC00000, 24'h000000};
      blk_sc  = '{8'd5, 8'd3, 8'd4, 8'd0};
      blk_exp = '{8'h40, 8'h10, 8'hE0, 8'h00};
      run_block("align", 8'd5, 1'b0);

      // Guard/sticky/tie/saturation patterns
      blk_op  = '{24'h3FC000, 24'h418000, 24'h408000, 24'h7FC000};
      blk_sc  = '{8'd2, 8'd2, 8'd2, 8'd2};
`ifdef MX_ALIGN_RNE_EN
      blk_exp = '{8'h40, 8'h42, 8'h40, 8'h7F};
`else
      blk_exp = '{8'h3F, 8'h41, 8'h40, 8'h7F};
`endif
      run_block("round", 8'd2, 1'b0);

      // Shifts at or beyond the element width
      blk_op  = '{24'h400000, 24'h800000, 24'h7FFFFF, 24'h000001};
      blk_sc  = '{8'd40, 8'd0, 8'd0, 8'd0};
`ifdef MX_ALIGN_RNE_EN
      blk_exp = '{8'h40, 8'h00, 8'h00, 8'h00};
`else
      blk_exp = '{8'h40, 8'hFF, 8'h00, 8'h00};
`endif
      run_block("bigshift", 8'd40, 1'b0);

      // Input gaps, output stalls, junk offered during the output phase
      blk_op  = '{24'h120000, 24'h340000, 24'hF00000, 24'h080000};
      blk_sc  = '{8'd3, 8'd3, 8'd2, 8'd1};
      blk_exp = '{8'h12, 8'h34, 8'hF8, 8'h02};
      run_block("hshake", 8'd3, 1'b1);
      run_block("hshake2", 8'd3, 1'b1);

      // Reset after two accepts, then a fresh block with max scale 1
      push(24'h7F0000, 8'd7);
      push(24'h7F0000, 8'd9);
      @(negedge i_clk);
      i_valid = 1'b0;
      pulse_reset("collect");
      blk_op  = '{24'h100000, 24'h200000, 24'h400000, 24'hE00000};
      blk_sc  = '{8'd1, 8'd0, 8'd1, 8'd0};
      blk_exp = '{8'h10, 8'h10, 8'h40, 8'hF0};
      run_block("post reset", 8'd1, 1'b0);

      // Reset while a block is being emitted
      for (int i = 0; i < BLOCK_K; i++) push(24'h500000, 8'd6);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 1'b0;
      check("emit pre-reset valid", 32'(o_valid), 1);
      pulse_reset("emit");
      i_ready = 1'b1;
      run_block("post emit reset", 8'd1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
